// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables, flush/bubble, stall counter,
// and data-memory timeout detection.
module hazard_ctrl #(
  parameter int STALL_CNT_W = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_use_stall_i,
  input  logic                   branch_taken_i,
  input  logic                   dmem_req_i,
  input  logic                   dmem_ack_i,
  input  logic                   imem_valid_i,
  output logic                   if_en_o,
  output logic                   id_en_o,
  output logic                   ex_en_o,
  output logic                   mem_en_o,
  output logic                   wb_en_o,
  output logic                   if_id_flush_o,
  output logic                   id_ex_bubble_o,
  output logic [1:0]             state_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o,
  output logic                   mem_timeout_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [16:0] TMO = 17'(MEM_TIMEOUT);

  state_t state_q;
  state_t state_d;
  state_t run_nxt;

  logic       mem_busy;
  logic [4:0] run_en;
  logic       run_flush;
  logic       run_bubble;
  logic [4:0] en;
  logic       flush;
  logic       bubble;
  logic       stall;

  logic [15:0] wait_cnt;
  logic [16:0] wait_nxt;
  logic        wait_cyc;

  logic [STALL_CNT_W-1:0] stall_cnt;

  assign mem_busy = dmem_req_i & ~dmem_ack_i;

  // RUN rules 2..5, reused on the MEM_WAIT ack cycle
  always_comb begin
    run_en     = 5'b11111;
    run_flush  = 1'b0;
    run_bubble = 1'b0;
    run_nxt    = RUN;
    if (branch_taken_i) begin
      run_flush  = 1'b1;
      run_bubble = 1'b1;
      if (!imem_valid_i)
        run_nxt = REDIRECT;
    end else if (load_use_stall_i) begin
      run_en     = 5'b00111;
      run_bubble = 1'b1;
    end else if (!imem_valid_i) begin
      run_flush = 1'b1;
    end
  end

  always_comb begin
    en      = 5'b11111;
    flush   = 1'b0;
    bubble  = 1'b0;
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          en      = 5'b00000;
          state_d = MEM_WAIT;
        end else begin
          en      = run_en;
          flush   = run_flush;
          bubble  = run_bubble;
          state_d = run_nxt;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ack_i) begin
          en = 5'b00000;
        end else begin
          en      = run_en;
          flush   = run_flush;
          bubble  = run_bubble;
          state_d = run_nxt;
        end
      end
      REDIRECT: begin
        if (mem_busy) begin
          en      = 5'b00000;
          state_d = MEM_WAIT;
        end else if (!imem_valid_i) begin
          flush = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        en      = 5'b00000;
        state_d = RUN;
      end
    endcase
  end

  // Reset overrides everything so no stage captures garbage
  always_comb begin
    if (!rst_ni) begin
      if_en_o        = 1'b0;
      id_en_o        = 1'b0;
      ex_en_o        = 1'b0;
      mem_en_o       = 1'b0;
      wb_en_o        = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else begin
      if_en_o        = en[4];
      id_en_o        = en[3];
      ex_en_o        = en[2];
      mem_en_o       = en[1];
      wb_en_o        = en[0];
      if_id_flush_o  = flush;
      id_ex_bubble_o = bubble;
    end
  end

  assign stall    = ~en[4] | bubble;
  assign wait_cyc = (state_q == MEM_WAIT) & ~dmem_ack_i;
  assign wait_nxt = {1'b0, wait_cnt} + 17'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      stall_cnt     <= '0;
      wait_cnt      <= '0;
      mem_timeout_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (wait_cyc) begin
        if (wait_cnt != 16'hFFFF)
          wait_cnt <= wait_nxt[15:0];
        if (wait_nxt >= TMO)
          mem_timeout_o <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign state_o        = state_q;
  assign stall_cycles_o = stall_cnt;

endmodule
